// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter datapath and its controller.
//   op_t     : 3-bit micro-op encoding issued by the controller
//   R00..R10 : symbolic register-file indices
//   DATA_W   : default external sample/coefficient width
//   reg_t    : signed working-register type (DATA_W+1 bits)
package fir_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W:0] reg_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  localparam logic [3:0] R00 = 4'd0;
  localparam logic [3:0] R01 = 4'd1;
  localparam logic [3:0] R02 = 4'd2;
  localparam logic [3:0] R03 = 4'd3;
  localparam logic [3:0] R04 = 4'd4;
  localparam logic [3:0] R05 = 4'd5;
  localparam logic [3:0] R06 = 4'd6;
  localparam logic [3:0] R07 = 4'd7;
  localparam logic [3:0] R08 = 4'd8;
  localparam logic [3:0] R09 = 4'd9;
  localparam logic [3:0] R10 = 4'd10;

endpackage

// File: rtl/fir_datapath_regfile.sv
// fir_regfile: NREGS x (DATA_W+1) signed working register file.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset (clears all entries)
//   rd_addr1/rd_data1 combinational read port 1
//   rd_addr2/rd_data2 combinational read port 2
//   wr_en/wr_addr/wr_data single write port, lands at the clock edge
//   r0                entry 0, brought out directly
module fir_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREGS)-1:0]   rd_addr1,
  input  logic [$clog2(NREGS)-1:0]   rd_addr2,
  output logic signed [DATA_W:0]     rd_data1,
  output logic signed [DATA_W:0]     rd_data2,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_addr,
  input  logic signed [DATA_W:0]     wr_data,
  output logic signed [DATA_W:0]     r0
);

  logic signed [DATA_W:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads see pre-edge state, so a read of the entry being written returns the old value.
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
  assign r0       = regs[0];

endmodule

// File: rtl/fir_datapath.sv
// fir_datapath: executes one controller micro-op per clock on a signed register file.
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   op, src1, src2, dest   micro-op and register indices
//   ext_data1, ext_data2   unsigned sample / coefficient inputs (zero-extended on load)
//   outreg_data            current contents of R0 (signed)
//   overflow               registered overflow flag of the previous ADD/SUB/MUL
// Build option: define SATURATE_EN to clamp overflowing results instead of wrapping.
module fir_datapath #(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int NREGS  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 op,
  input  logic [$clog2(NREGS)-1:0]   src1,
  input  logic [$clog2(NREGS)-1:0]   src2,
  input  logic [$clog2(NREGS)-1:0]   dest,
  input  logic [DATA_W-1:0]          ext_data1,
  input  logic [DATA_W-1:0]          ext_data2,
  output logic signed [DATA_W:0]     outreg_data,
  output logic                       overflow
);

  import fir_pkg::*;

  // Wide enough for an exact product; add/sub results are sign-extended into it.
  localparam int FULL_W = 2 * (DATA_W + 1);

  localparam logic signed [FULL_W-1:0] FULL_MAX = {{(DATA_W+2){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [FULL_W-1:0] FULL_MIN = {{(DATA_W+2){1'b1}}, {DATA_W{1'b0}}};

  op_t                      opc;
  logic signed [DATA_W:0]   a;
  logic signed [DATA_W:0]   b;
  logic signed [DATA_W:0]   wdata;
  logic signed [FULL_W-1:0] full;
  logic                     wen;
  logic                     arith;
  logic                     ovf;

  assign opc = op_t'(op);

  always_comb begin
    wen   = 1'b0;
    arith = 1'b0;
    full  = '0;
    wdata = a;
    case (opc)
      OP_COPY: begin
        wen   = 1'b1;
        wdata = a;
      end
      OP_LOAD1: begin
        wen   = 1'b1;
        wdata = {1'b0, ext_data1};
      end
      OP_LOAD2: begin
        wen   = 1'b1;
        wdata = {1'b0, ext_data2};
      end
      OP_ADD: begin
        arith = 1'b1;
        full  = FULL_W'(a) + FULL_W'(b);
      end
      OP_SUB: begin
        arith = 1'b1;
        full  = FULL_W'(a) - FULL_W'(b);
      end
      OP_MUL: begin
        arith = 1'b1;
        full  = FULL_W'(a) * FULL_W'(b);
      end
      default: ;
    endcase

    ovf = arith && ((full > FULL_MAX) || (full < FULL_MIN));

    if (arith) begin
      wen   = 1'b1;
      wdata = full[DATA_W:0];
`ifdef SATURATE_EN
      if (ovf) begin
        wdata = full[FULL_W-1] ? {1'b1, {DATA_W{1'b0}}} : {1'b0, {DATA_W{1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ovf;
    end
  end

  fir_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (src1),
    .rd_addr2 (src2),
    .rd_data1 (a),
    .rd_data2 (b),
    .wr_en    (wen),
    .wr_addr  (dest),
    .wr_data  (wdata),
    .r0       (outreg_data)
  );

endmodule

// File: tb/tb_fir_datapath.sv
module tb_fir_datapath;
  import fir_pkg::*;

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Expected R0 for a positive overflow, and for the -131070 negative overflow case.
  localparam logic [16:0] OVP = SAT ? 17'h0FFFF : 17'h10000;
  localparam logic [16:0] OVN = SAT ? 17'h10000 : 17'h00002;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] ext_data1, ext_data2;
  logic [16:0] outreg_data;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  fir_datapath #(
    .DATA_W (16),
    .NREGS  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .ext_data1   (ext_data1),
    .ext_data2   (ext_data2),
    .outreg_data (outreg_data),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural reference: registers as plain integers in [-65536, 65535].
  int m [16];
  bit movf;

  function automatic int wrap17(input longint v);
    longint w;
    w = v & 64'h1FFFF;
    if (w >= 65536) w = w - 131072;
    return int'(w);
  endfunction

  task automatic model(input bit r, input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    longint x, y, full;
    bit ov;
    if (r) begin
      foreach (m[i]) m[i] = 0;
      movf = 0;
      return;
    end
    x = m[s1];
    y = m[s2];
    movf = 0;
    case (o)
      3'd1: m[d] = int'(x);
      3'd2: m[d] = int'(e1);
      3'd3: m[d] = int'(e2);
      3'd4, 3'd5, 3'd6: begin
        full = (o == 3'd4) ? x + y : (o == 3'd5) ? x - y : x * y;
        ov = (full > 65535) || (full < -65536);
        movf = ov;
        if (!ov) m[d] = int'(full);
        else if (SAT) m[d] = (full > 0) ? 65535 : -65536;
        else m[d] = wrap17(full);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    @(negedge clk);
    rst = r; op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          r;
    logic [2:0]  o;
    logic [3:0]  s1, s2, d;
    logic [15:0] e1, e2;
    logic [16:0] r0;
    bit          ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input op_t o, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2,
                              input logic [16:0] r0, input bit ovf);
    vec_t v;
    v.r = r; v.o = o; v.s1 = s1; v.s2 = s2; v.d = d; v.e1 = e1; v.e2 = e2; v.r0 = r0; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    // Directed table: each row is one clock with the R0/overflow values expected after its edge.
    add(0, OP_LOAD1, R00, R00, R01, 16'd5,    16'd0,    17'h00000, 0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'd3,    17'h00000, 0);
    add(0, OP_MUL,   R01, R02, R03, 16'd0,    16'd0,    17'h00000, 0);
    add(0, OP_COPY,  R03, R00, R00, 16'd0,    16'd0,    17'h0000F, 0);
    add(0, OP_LOAD1, R00, R00, R01, 16'd3,    16'd0,    17'h0000F, 0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'd5,    17'h0000F, 0);
    add(0, OP_SUB,   R01, R02, R00, 16'd0,    16'd0,    17'h1FFFE, 0);
    add(0, OP_LOAD1, R00, R00, R01, 16'hFFFF, 16'd0,    17'h1FFFE, 0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'd1,    17'h1FFFE, 0);
    add(0, OP_ADD,   R01, R02, R00, 16'd0,    16'd0,    OVP,       1);
    add(0, OP_NOP,   R00, R00, R00, 16'd0,    16'd0,    OVP,       0);
    add(0, OP_LOAD1, R00, R00, R01, 16'h0100, 16'd0,    OVP,       0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'h0100, OVP,       0);
    add(0, OP_MUL,   R01, R02, R00, 16'd0,    16'd0,    OVP,       1);
    add(0, OP_LOAD1, R00, R00, R01, 16'h00FF, 16'd0,    OVP,       0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'h0101, OVP,       0);
    add(0, OP_MUL,   R01, R02, R00, 16'd0,    16'd0,    17'h0FFFF, 0);
    add(0, OP_LOAD1, R00, R00, R07, 16'd100,  16'd0,    17'h0FFFF, 0);
    add(0, OP_ADD,   R07, R07, R07, 16'd0,    16'd0,    17'h0FFFF, 0);
    add(0, OP_COPY,  R07, R00, R00, 16'd0,    16'd0,    17'h000C8, 0);
    add(0, OP_LOAD1, R00, R00, R01, 16'd0,    16'd0,    17'h000C8, 0);
    add(0, OP_LOAD1, R00, R00, R02, 16'hFFFF, 16'd0,    17'h000C8, 0);
    add(0, OP_SUB,   R01, R02, R10, 16'd0,    16'd0,    17'h000C8, 0);
    add(0, OP_SUB,   R10, R02, R00, 16'd0,    16'd0,    OVN,       1);
    add(0, OP_LOAD1, R00, R00, R01, 16'hFFFF, 16'd0,    OVN,       0);
    add(0, OP_LOAD2, R00, R00, R02, 16'd0,    16'd1,    OVN,       0);
    add(0, OP_LOAD1, R00, R00, R05, 16'h1234, 16'd0,    OVN,       0);
    add(1, OP_ADD,   R01, R02, R05, 16'd0,    16'd0,    17'h00000, 0);
    add(0, OP_COPY,  R05, R00, R00, 16'd0,    16'd0,    17'h00000, 0);
    add(0, OP_LOAD1, R00, R00, R01, 16'h00AA, 16'd0,    17'h00000, 0);
    add(0, OP_LOAD1, R00, R00, R03, 16'hFFFF, 16'd0,    17'h00000, 0);
    add(0, OP_LOAD2, R00, R00, R04, 16'd0,    16'd1,    17'h00000, 0);
    add(0, OP_ADD,   R03, R04, R06, 16'd0,    16'd0,    17'h00000, 1);
    add(0, OP_RSVD,  R03, R04, R01, 16'h5555, 16'h5555, 17'h00000, 0);
    add(0, OP_COPY,  R01, R00, R00, 16'd0,    16'd0,    17'h000AA, 0);

    rst = 1'b1; op = '0; src1 = '0; src2 = '0; dest = '0; ext_data1 = '0; ext_data2 = '0;

    // Reset state.
    drive(1, 3'd0, 0, 0, 0, 16'd0, 16'd0);
    drive(1, 3'd0, 0, 0, 0, 16'd0, 16'd0);
    model(1, 3'd0, 0, 0, 0, 16'd0, 16'd0);
    check("reset_r0", outreg_data, 17'h0);
    check("reset_ovf", {16'd0, overflow}, 17'h0);

    // Randomized ops against the reference model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit          r;
      logic [2:0]  o;
      logic [3:0]  s1, s2, d;
      logic [15:0] e1, e2;
      r  = ($urandom_range(0, 31) == 0);
      o  = 3'($urandom_range(0, 7));
      s1 = 4'($urandom_range(0, 15));
      s2 = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      e1 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 400)) : 16'($urandom);
      e2 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 400)) : 16'($urandom);
      drive(r, o, s1, s2, d, e1, e2);
      model(r, o, s1, s2, d, e1, e2);
      check($sformatf("rand%0d_r0", i), outreg_data, 17'(m[0]));
      check($sformatf("rand%0d_ovf", i), {16'd0, overflow}, {16'd0, movf});
    end

    // Sweep every register into R0 to compare the full model state.
    for (int k = 1; k < 16; k++) begin
      int keep;
      keep = m[k];
      drive(0, 3'd1, 4'(k), 0, 0, 16'd0, 16'd0);
      model(0, 3'd1, 4'(k), 0, 0, 16'd0, 16'd0);
      check($sformatf("sweep_r%0d", k), outreg_data, 17'(keep));
    end

    // Reset after random activity: two cycles of rst with ops present.
    drive(1, 3'($urandom_range(1, 6)), 4'd1, 4'd2, 4'd0, 16'hFFFF, 16'hFFFF);
    drive(1, 3'd4, 4'd1, 4'd2, 4'd0, 16'hFFFF, 16'hFFFF);
    model(1, 3'd0, 0, 0, 0, 16'd0, 16'd0);
    check("rst2_r0", outreg_data, 17'h0);
    check("rst2_ovf", {16'd0, overflow}, 17'h0);
    for (int k = 1; k < 16; k++) begin
      drive(0, 3'd1, 4'(k), 0, 0, 16'd0, 16'd0);
      check($sformatf("rst2_r%0d", k), outreg_data, 17'h0);
    end

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].o, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].e1, tbl[i].e2);
      check($sformatf("vec%0d_r0", i), outreg_data, tbl[i].r0);
      check($sformatf("vec%0d_ovf", i), {16'd0, overflow}, {16'd0, tbl[i].ovf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
